// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg timer control front-end.
package egg_timer_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned ALARM_CNT_W = 8;

    typedef enum logic [2:0] {
        S_EDIT  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_ALARM = 3'd4
    } state_e;

    localparam logic [SEL_W-1:0] SEL_SEC_ONES = 2'd0;
    localparam logic [SEL_W-1:0] SEL_SEC_TENS = 2'd1;
    localparam logic [SEL_W-1:0] SEL_MIN_ONES = 2'd2;
    localparam logic [SEL_W-1:0] SEL_MIN_TENS = 2'd3;

    localparam logic [DIGIT_W-1:0] MAX_ONES     = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;
    localparam logic [DIGIT_W-1:0] MAX_MIN_TENS = 4'd9;

    // Wrap limit for the digit at a given edit position.
    function automatic logic [DIGIT_W-1:0] digit_max(input logic [SEL_W-1:0] sel);
        case (sel)
            SEL_SEC_TENS: digit_max = MAX_SEC_TENS;
            SEL_MIN_TENS: digit_max = MAX_MIN_TENS;
            default:      digit_max = MAX_ONES;
        endcase
    endfunction

endpackage

// File: rtl/egg_timer_ctrl_if.sv
// Load/enable handshake between the control front-end and the downcounter.
interface egg_timer_ctrl_if;
    import egg_timer_pkg::*;

    logic               tick_1hz;
    logic [DIGIT_W-1:0] cur_min_tens;
    logic [DIGIT_W-1:0] cur_min_ones;
    logic [DIGIT_W-1:0] cur_sec_tens;
    logic [DIGIT_W-1:0] cur_sec_ones;
    logic [DIGIT_W-1:0] load_min_tens;
    logic [DIGIT_W-1:0] load_min_ones;
    logic [DIGIT_W-1:0] load_sec_tens;
    logic [DIGIT_W-1:0] load_sec_ones;
    logic               load;
    logic               enable;

    modport master (
        input  tick_1hz,
        input  cur_min_tens, cur_min_ones, cur_sec_tens, cur_sec_ones,
        output load_min_tens, load_min_ones, load_sec_tens, load_sec_ones,
        output load, enable
    );

    modport slave (
        output tick_1hz,
        output cur_min_tens, cur_min_ones, cur_sec_tens, cur_sec_ones,
        input  load_min_tens, load_min_ones, load_sec_tens, load_sec_ones,
        input  load, enable
    );

endinterface

// File: rtl/bcd_digit_edit.sv
// Combinational wrap-around increment/decrement of one BCD digit up to i_max.
module bcd_digit_edit
    import egg_timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic [DIGIT_W-1:0] i_max,
    output logic [DIGIT_W-1:0] o_inc_c,
    output logic [DIGIT_W-1:0] o_dec_c
);

    // Out-of-range digits fold back into range on either operation.
    assign o_inc_c = (i_digit >= i_max) ? '0 : DIGIT_W'(i_digit + 4'd1);
    assign o_dec_c = ((i_digit == '0) || (i_digit > i_max)) ? i_max
                                                            : DIGIT_W'(i_digit - 4'd1);

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer control: preset editing, load/enable handshake to the downcounter, alarm.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int unsigned DEF_MIN_TENS = 0,
    parameter int unsigned DEF_MIN_ONES = 3,
    parameter int unsigned DEF_SEC_TENS = 0,
    parameter int unsigned DEF_SEC_ONES = 0,
    parameter int unsigned ALARM_SECS   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_next,
    input  logic                 btn_start,
    egg_timer_ctrl_if.master     bus,
    output logic                 alarm,
    output logic [SEL_W-1:0]     edit_sel,
    output logic                 editing
);

    localparam logic [NUM_DIGITS-1:0][DIGIT_W-1:0] DEF_DIGITS = {
        DIGIT_W'(DEF_MIN_TENS), DIGIT_W'(DEF_MIN_ONES),
        DIGIT_W'(DEF_SEC_TENS), DIGIT_W'(DEF_SEC_ONES)
    };
    localparam logic [ALARM_CNT_W-1:0] ALARM_LIMIT = ALARM_CNT_W'(ALARM_SECS);

    state_e                             r_state,      w_state_nxt;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_digits,     w_digits_nxt;
    logic [SEL_W-1:0]                   r_edit_sel,   w_edit_sel_nxt;
    logic                               r_load,       w_load_nxt;
    logic                               r_enable,     w_enable_nxt;
    logic                               r_alarm,      w_alarm_nxt;
    logic [ALARM_CNT_W-1:0]             r_alarm_cnt,  w_alarm_cnt_nxt;
    logic                               r_settle,     w_settle_nxt;
    logic                               r_editing;

    logic [DIGIT_W-1:0]     w_inc_c;
    logic [DIGIT_W-1:0]     w_dec_c;
    logic [ALARM_CNT_W-1:0] w_alarm_cnt_inc;
    logic                   w_any_btn;
    logic                   w_preset_zero;
    logic                   w_cur_zero;

    bcd_digit_edit u_digit_edit (
        .i_digit (r_digits[r_edit_sel]),
        .i_max   (digit_max(r_edit_sel)),
        .o_inc_c (w_inc_c),
        .o_dec_c (w_dec_c)
    );

    assign w_any_btn       = btn_up | btn_down | btn_next | btn_start;
    assign w_preset_zero   = (r_digits == '0);
    assign w_cur_zero      = (bus.cur_min_tens == '0) && (bus.cur_min_ones == '0) &&
                             (bus.cur_sec_tens == '0) && (bus.cur_sec_ones == '0);
    assign w_alarm_cnt_inc = ALARM_CNT_W'(r_alarm_cnt + 8'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_EDIT;
            r_digits    <= DEF_DIGITS;
            r_edit_sel  <= SEL_MIN_TENS;
            r_load      <= 1'b0;
            r_enable    <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
            r_settle    <= 1'b0;
            r_editing   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_digits    <= w_digits_nxt;
            r_edit_sel  <= w_edit_sel_nxt;
            r_load      <= w_load_nxt;
            r_enable    <= w_enable_nxt;
            r_alarm     <= w_alarm_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
            r_settle    <= w_settle_nxt;
            r_editing   <= (w_state_nxt == S_EDIT);
        end
    end

    // Next state and next registered outputs; buttons follow start > next > up > down.
    always_comb begin
        w_state_nxt     = r_state;
        w_digits_nxt    = r_digits;
        w_edit_sel_nxt  = r_edit_sel;
        w_load_nxt      = r_load;
        w_enable_nxt    = r_enable;
        w_alarm_nxt     = r_alarm;
        w_alarm_cnt_nxt = r_alarm_cnt;
        w_settle_nxt    = r_settle;

        case (r_state)
            S_EDIT: begin
                if (btn_start) begin
                    if (!w_preset_zero) begin
                        w_state_nxt = S_ARM;
                        w_load_nxt  = 1'b1;
                    end
                end else if (btn_next) begin
                    w_edit_sel_nxt = SEL_W'(r_edit_sel - 2'd1);
                end else if (btn_up) begin
                    w_digits_nxt[r_edit_sel] = w_inc_c;
                end else if (btn_down) begin
                    w_digits_nxt[r_edit_sel] = w_dec_c;
                end
            end
            S_ARM: begin
                // Downcounter samples load on this same tick edge.
                if (bus.tick_1hz) begin
                    w_state_nxt  = S_RUN;
                    w_load_nxt   = 1'b0;
                    w_enable_nxt = 1'b1;
                    w_settle_nxt = 1'b1;
                end
            end
            S_RUN: begin
                w_settle_nxt = 1'b0;
                // Counter digits may still be stale in the first run cycle.
                if (!r_settle && w_cur_zero) begin
                    w_state_nxt     = S_ALARM;
                    w_enable_nxt    = 1'b0;
                    w_alarm_nxt     = 1'b1;
                    w_alarm_cnt_nxt = '0;
                end else if (btn_start) begin
                    w_state_nxt  = S_PAUSE;
                    w_enable_nxt = 1'b0;
                end
            end
            S_PAUSE: begin
                if (btn_start) begin
                    w_state_nxt  = S_RUN;
                    w_enable_nxt = 1'b1;
                    w_settle_nxt = 1'b1;
                end else if (btn_next) begin
                    w_state_nxt = S_EDIT;
                end
            end
            S_ALARM: begin
                if (w_any_btn) begin
                    w_state_nxt = S_EDIT;
                    w_alarm_nxt = 1'b0;
                end else if (bus.tick_1hz) begin
                    w_alarm_cnt_nxt = w_alarm_cnt_inc;
                    if (w_alarm_cnt_inc == ALARM_LIMIT) begin
                        w_state_nxt = S_EDIT;
                        w_alarm_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt  = S_EDIT;
                w_load_nxt   = 1'b0;
                w_enable_nxt = 1'b0;
                w_alarm_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.load_min_tens = r_digits[SEL_MIN_TENS];
    assign bus.load_min_ones = r_digits[SEL_MIN_ONES];
    assign bus.load_sec_tens = r_digits[SEL_SEC_TENS];
    assign bus.load_sec_ones = r_digits[SEL_SEC_ONES];
    assign bus.load          = r_load;
    assign bus.enable        = r_enable;
    assign alarm             = r_alarm;
    assign edit_sel          = r_edit_sel;
    assign editing           = r_editing;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with a behavioural MM:SS downcounter.
module tb_egg_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_next, btn_start;
    logic       alarm, editing;
    logic [1:0] edit_sel;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [3:0][3:0] dc = '0;   // {min_tens, min_ones, sec_tens, sec_ones}

    egg_timer_ctrl_if u_if ();

    egg_timer_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_next  (btn_next),
        .btn_start (btn_start),
        .bus       (u_if),
        .alarm     (alarm),
        .edit_sel  (edit_sel),
        .editing   (editing)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0][3:0] d;
        d = v;
        if (d[0] != 0) d[0] = d[0] - 4'd1;
        else begin
            d[0] = 4'd9;
            if (d[1] != 0) d[1] = d[1] - 4'd1;
            else begin
                d[1] = 4'd5;
                if (d[2] != 0) d[2] = d[2] - 4'd1;
                else begin
                    d[2] = 4'd9;
                    d[3] = d[3] - 4'd1;
                end
            end
        end
        return d;
    endfunction

    // Downcounter: loads or counts only on the 1 Hz edge.
    always @(posedge clk) begin
        if (u_if.tick_1hz) begin
            if (u_if.load)
                dc <= {u_if.load_min_tens, u_if.load_min_ones, u_if.load_sec_tens, u_if.load_sec_ones};
            else if (u_if.enable && (dc != '0))
                dc <= bcd_dec(dc);
        end
    end

    assign u_if.cur_min_tens = dc[3];
    assign u_if.cur_min_ones = dc[2];
    assign u_if.cur_sec_tens = dc[1];
    assign u_if.cur_sec_ones = dc[0];

    function automatic logic [15:0] preset();
        return {u_if.load_min_tens, u_if.load_min_ones, u_if.load_sec_tens, u_if.load_sec_ones};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic up, input logic dn, input logic nx, input logic st);
        @(negedge clk);
        btn_up = up; btn_down = dn; btn_next = nx; btn_start = st;
        @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0; btn_start = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        u_if.tick_1hz = 1'b1;
        @(negedge clk);
        u_if.tick_1hz = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_next = 1'b0; btn_start = 1'b0;
        u_if.tick_1hz = 1'b0;
        idle(2);
        reset = 1'b1;
        idle(1);

        chk("rst_preset",  32'(preset()), 32'h0300);
        chk("rst_sel",     32'(edit_sel), 32'd3);
        chk("rst_load",    32'(u_if.load), 32'd0);
        chk("rst_enable",  32'(u_if.enable), 32'd0);
        chk("rst_alarm",   32'(alarm), 32'd0);
        chk("rst_editing", 32'(editing), 32'd1);

        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        chk("sel_to_1", 32'(edit_sel), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            press(1, 0, 0, 0);
            chk($sformatf("sec_tens_up%0d", i), 32'(u_if.load_sec_tens), 32'(i % 6));
        end
        press(0, 1, 0, 0);
        chk("sec_tens_dn_wrap", 32'(u_if.load_sec_tens), 32'd5);

        // Build preset 00:02
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        chk("sel_wrap_to_2", 32'(edit_sel), 32'd2);
        repeat (3) press(0, 1, 0, 0);
        chk("preset_0002", 32'(preset()), 32'h0002);

        press(0, 0, 0, 1);
        chk("arm_load", 32'(u_if.load), 32'd1);
        chk("arm_editing", 32'(editing), 32'd0);
        press(1, 0, 0, 0);
        idle(2);
        chk("arm_load_held", 32'(u_if.load), 32'd1);
        chk("arm_btn_ignored", 32'(preset()), 32'h0002);
        chk("arm_enable", 32'(u_if.enable), 32'd0);
        tick();
        chk("run_load", 32'(u_if.load), 32'd0);
        chk("run_enable", 32'(u_if.enable), 32'd1);
        chk("dc_loaded", 32'(dc), 32'h0002);
        tick();
        chk("run_alarm0", 32'(alarm), 32'd0);
        tick();
        chk("dc_zero", 32'(dc), 32'h0000);
        chk("alarm_not_yet", 32'(alarm), 32'd0);
        idle(1);
        chk("alarm_set", 32'(alarm), 32'd1);
        chk("alarm_enable", 32'(u_if.enable), 32'd0);
        repeat (9) tick();
        chk("alarm_held_9", 32'(alarm), 32'd1);
        tick();
        chk("alarm_cleared", 32'(alarm), 32'd0);
        chk("alarm_to_edit", 32'(editing), 32'd1);
        chk("alarm_preset_kept", 32'(preset()), 32'h0002);

        // Pause / resume / cancel
        press(0, 0, 0, 1);
        tick();
        chk("run2_enable", 32'(u_if.enable), 32'd1);
        press(0, 0, 0, 1);
        chk("pause_enable", 32'(u_if.enable), 32'd0);
        chk("pause_alarm", 32'(alarm), 32'd0);
        press(0, 0, 0, 1);
        chk("resume_enable", 32'(u_if.enable), 32'd1);
        press(0, 0, 0, 1);
        press(0, 0, 1, 0);
        chk("cancel_editing", 32'(editing), 32'd1);
        chk("cancel_enable", 32'(u_if.enable), 32'd0);
        chk("cancel_preset", 32'(preset()), 32'h0002);
        chk("cancel_sel", 32'(edit_sel), 32'd2);

        // Zero preset cannot start
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        chk("preset_0000", 32'(preset()), 32'h0000);
        press(0, 0, 0, 1);
        chk("zero_start_editing", 32'(editing), 32'd1);
        idle(3);
        chk("zero_start_load", 32'(u_if.load), 32'd0);

        // Start and up together: only start acts
        press(1, 0, 0, 0);
        chk("preset_0001", 32'(preset()), 32'h0001);
        press(1, 0, 0, 1);
        chk("prio_load", 32'(u_if.load), 32'd1);
        chk("prio_editing", 32'(editing), 32'd0);
        chk("prio_preset", 32'(preset()), 32'h0001);

        // Asynchronous reset during arm
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_load", 32'(u_if.load), 32'd0);
        chk("async_preset", 32'(preset()), 32'h0300);
        chk("async_sel", 32'(edit_sel), 32'd3);
        chk("async_editing", 32'(editing), 32'd1);
        idle(1);
        reset = 1'b1;
        idle(2);
        chk("post_rst_load", 32'(u_if.load), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/egg_timer_ctrl.md
Name: egg_timer_ctrl

Overview:
- Control front-end for the egg timer. It sits on the producer side of the timer's load/enable interface.
- Users edit a 4-digit MM:SS preset with pushbuttons. The block presents the preset on the load buses and drives a load/enable handshake into the downcounter.
- It watches the counter's digit outputs to raise an alarm at 00:00.
- It runs on the system clock. The downcounter's 1 Hz edge is seen here as a one-cycle strobe, tick_1hz.

Parameters:
- DEF_MIN_TENS, 0: preset value of minute-tens at reset.
- DEF_MIN_ONES, 3: preset value of minute-ones at reset.
- DEF_SEC_TENS, 0: preset value of second-tens at reset.
- DEF_SEC_ONES, 0: preset value of second-ones at reset.
- ALARM_SECS, 10: number of tick_1hz strobes the alarm stays asserted (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  single-cycle strobe, coincident with the downcounter's 1 Hz clock edge.
- btn_up, btn_down, btn_next, btn_start  in  1 each  debounced single-cycle button pulses.
- cur_min_tens, cur_min_ones, cur_sec_tens, cur_sec_ones  in  4 each  downcounter digit outputs.
- load_min_tens, load_min_ones, load_sec_tens, load_sec_ones  out  4 each  preset digits.
- load  out  1  level; held until the downcounter has sampled it.
- enable  out  1  downcounter count enable.
- alarm  out  1  expiry indicator.
- edit_sel  out  2  digit under edit: 0=sec_ones, 1=sec_tens, 2=min_ones, 3=min_tens (for display blink).
- editing  out  1  high in S_EDIT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_EDIT, load buses=DEF_* parameters, edit_sel=3, load=0, enable=0, alarm=0, alarm count=0.
- All outputs are registered. Buttons are acted on in the cycle they are high and take effect on the next clk edge.
- Same-cycle button priority: start > next > up > down. Only the highest-priority button is acted on.
- States: S_EDIT, S_ARM, S_RUN, S_PAUSE, S_ALARM.
- S_EDIT:
  - btn_up increments the selected digit with wrap. Ones digits and min_tens wrap 9->0; sec_tens wraps 5->0.
  - btn_down decrements with wrap. Ones digits and min_tens wrap 0->9; sec_tens wraps 0->5.
  - btn_next: edit_sel decrements 3->2->1->0->3.
  - btn_start with preset != 00:00: go to S_ARM, load=1.
  - btn_start with preset == 00:00: ignored, stay in S_EDIT.
- S_ARM:
  - load=1, enable=0.
  - On tick_1hz: load=0, enable=1, go to S_RUN. The downcounter samples load on that same edge.
  - Buttons are ignored.
- S_RUN:
  - enable=1.
  - btn_start: enable=0, go to S_PAUSE.
  - Zero check is skipped in the first S_RUN cycle (downcounter outputs settling). From the second cycle onward, cur digits all 0 gives enable=0, alarm=1, alarm count=0, go to S_ALARM.
  - Zero detection has priority over btn_start in the same cycle.
- S_PAUSE:
  - enable=0.
  - btn_start: enable=1, go to S_RUN; the settle-skip applies again.
  - btn_next: go to S_EDIT, cancelling the run. The preset is retained.
  - up/down are ignored.
- S_ALARM:
  - alarm=1.
  - Each tick_1hz increments the alarm count. When the count reaches ALARM_SECS: alarm=0, go to S_EDIT.
  - Any button: alarm=0, go to S_EDIT. The button is consumed and does not edit.
- The load buses change only in S_EDIT, so they are stable throughout S_ARM.
- In S_EDIT, edit_sel is unchanged on entry.
- Reset asserted mid-run drops load/enable immediately. The downcounter keeps its digits until its own reset.

Decomposition:
- Package egg_timer_pkg holds:
  - the state encoding;
  - digit index constants (SEL_SEC_ONES..SEL_MIN_TENS);
  - digit maxima: MAX_ONES=9, MAX_SEC_TENS=5, MAX_MIN_TENS=9.
- One sub-module, bcd_digit_edit: combinational inc/dec with wrap for a 4-bit digit and a given maximum. Instantiate it once on the selected digit.

Test Plan:
- Reset then release → load buses 0,3,0,0; edit_sel=3; load=0, enable=0, alarm=0.
- edit_sel=1, btn_up ×6 from 0 → sec_tens sequence 1,2,3,4,5,0. Then btn_down once → 5.
- Preset 00:02, btn_start → load=1 until the first tick_1hz, then load=0 and enable=1 on the same edge. Downcounter model reaches 00:00 on the 2nd tick → alarm=1 on the second cycle after 00:00 is observed, enable=0. After ALARM_SECS=10 ticks → S_EDIT, alarm=0.
- Preset 00:00, btn_start → remains in S_EDIT, load never rises.
- In S_RUN: btn_start → enable=0. btn_start again → enable=1. btn_start then btn_next → S_EDIT with preset unchanged.
- btn_start and btn_up in the same S_EDIT cycle → only start acts: S_ARM entered, digits unchanged.
- Reset pulsed low during S_ARM → load=0 asynchronously, preset returns to defaults.
